// File: rtl/fpmult_pkg.sv
// Shared definitions for the 8-bit float multiplier pack stage:
// format widths, FSM state encoding, exception bundle and special encodings.
package fpmult_pkg;

  localparam int BIAS     = 3;
  localparam int EXP_W    = 3;
  localparam int MANT_W   = 4;
  localparam int WORD_W   = 1 + EXP_W + MANT_W;
  localparam int EXPSUM_W = 5;
  localparam int PROD_W   = 10;
  localparam int EXC_W    = 5;
  localparam int FLAG_W   = 4;

  localparam logic [WORD_W-1:0] QNAN    = 8'h7C;
  localparam logic [EXP_W-1:0]  EXP_MAX = 3'b111;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;

  // Exception bits as delivered by the operand prep stage.
  typedef struct packed {
    logic zero;
    logic a_nan;
    logic b_nan;
    logic a_inf;
    logic b_inf;
  } exc_t;

endpackage

// File: rtl/fpmult_pack_module_if.sv
// Operand/result handshake bundle between the prep stage, this pack stage
// and the result consumer.
interface fpmult_pack_module_if;
  import fpmult_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                sign;
  logic [EXPSUM_W-1:0] exp_sum;
  logic [PROD_W-1:0]   mant_prod;
  logic [EXC_W-1:0]    exc;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   result;
  logic [FLAG_W-1:0]   flags;

  // Producer/consumer side
  modport master (
    output in_valid, sign, exp_sum, mant_prod, exc, out_ready,
    input  in_ready, out_valid, result, flags
  );

  // Pack stage side
  modport slave (
    input  in_valid, sign, exp_sum, mant_prod, exc, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fpmult_round_rne.sv
// Round-to-nearest-even on the 4-bit fraction; a carry out of the fraction
// leaves it at 0000 and bumps the exponent (the significand becomes 10.0000).
module fpmult_round_rne
  import fpmult_pkg::*;
#(
  parameter int EW = 6
) (
  input  logic [MANT_W-1:0]    mant_in,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic signed [EW-1:0] exp_in,
  output logic [MANT_W-1:0]    mant_out,
  output logic signed [EW-1:0] exp_out,
  output logic                 inexact
);

  logic            round_up;
  logic [MANT_W:0] mant_sum;
  logic signed [EW-1:0] exp_bump;

  // Increment on guard when above half (sticky) or exactly half with odd lsb.
  always_comb begin
    round_up = guard & (sticky | mant_in[0]);
    mant_sum = {1'b0, mant_in} + {{MANT_W{1'b0}}, round_up};
    mant_out = mant_sum[MANT_W-1:0];
    exp_bump = mant_sum[MANT_W] ? EW'(1) : '0;
    exp_out  = exp_in + exp_bump;
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/fpmult_pack_module.sv
// Pack stage of the 8-bit float multiplier: normalises the raw significand
// product, rounds it, resolves exceptions and holds the packed result until
// the consumer takes it. One bundle in flight at a time.
module fpmult_pack_module #(
  parameter int BIAS = fpmult_pkg::BIAS
) (
  input logic                  clk,
  input logic                  rst,
  fpmult_pack_module_if.slave  bus
);
  import fpmult_pkg::*;

  // Working exponent: room for the largest biased sum plus the normalise and
  // rounding bumps, and for the negative sums of tiny operands.
  localparam int EW = $clog2(2 * (2**EXP_W - 1) + BIAS + 2) + 1;
  localparam logic signed [EW-1:0] EXP_ONE  = 1;
  localparam logic signed [EW-1:0] EXP_OVF  = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  state_t               state_reg, state_next;
  logic                 sign_reg;
  logic signed [EW-1:0] exp_reg;
  logic [PROD_W-1:0]    mant_reg;
  logic [7:0]           frac_reg;
  logic                 sticky_reg;
  logic [WORD_W-1:0]    result_reg;
  logic [FLAG_W-1:0]    flags_reg;

  exc_t                 exc_in;
  logic [WORD_W-1:0]    exc_result;
  logic [FLAG_W-1:0]    exc_flags;
  logic [MANT_W-1:0]    mant_rnd;
  logic signed [EW-1:0] exp_rnd;
  logic                 inexact_rnd;
  logic [WORD_W-1:0]    pack_result;
  logic [FLAG_W-1:0]    pack_flags;

  assign exc_in     = exc_t'(bus.exc);
  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state and handshake outputs; exceptional bundles skip straight to HOLD.
  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = (|bus.exc) ? HOLD : NORM;
      end
      NORM:  state_next = ROUND;
      ROUND: state_next = HOLD;
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Exception result, priority NaN/invalid > infinity > zero.
  always_comb begin
    exc_flags = '0;
    if (exc_in.a_nan | exc_in.b_nan | (exc_in.zero & (exc_in.a_inf | exc_in.b_inf))) begin
      exc_result = {bus.sign, QNAN[WORD_W-2:0]};
      exc_flags  = 4'b1000;
    end else if (exc_in.a_inf | exc_in.b_inf) begin
      exc_result = {bus.sign, EXP_MAX, {MANT_W{1'b0}}};
    end else begin
      exc_result = {bus.sign, {(WORD_W-1){1'b0}}};
    end
  end

  // Fraction is frac_reg[7:4], guard frac_reg[3]; everything below plus any
  // bit lost by the normalise shift collapses into sticky.
  fpmult_round_rne #(.EW(EW)) u_round (
    .mant_in  (frac_reg[7:4]),
    .guard    (frac_reg[3]),
    .sticky   (sticky_reg | (|frac_reg[2:0])),
    .exp_in   (exp_reg),
    .mant_out (mant_rnd),
    .exp_out  (exp_rnd),
    .inexact  (inexact_rnd)
  );

  // Range check after rounding: saturate to infinity or flush to zero.
  always_comb begin
    if (exp_rnd >= EXP_OVF) begin
      pack_result = {sign_reg, EXP_MAX, {MANT_W{1'b0}}};
      pack_flags  = 4'b0101;
    end else if (exp_rnd <= EXP_ZERO) begin
      pack_result = {sign_reg, {(WORD_W-1){1'b0}}};
      pack_flags  = 4'b0011;
    end else begin
      pack_result = {sign_reg, exp_rnd[EXP_W-1:0], mant_rnd};
      pack_flags  = {3'b000, inexact_rnd};
    end
  end

  // Datapath: capture in IDLE, normalise in NORM, register the packed word in ROUND.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mant_reg   <= '0;
      frac_reg   <= '0;
      sticky_reg <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            sign_reg <= bus.sign;
            exp_reg  <= EW'($signed(bus.exp_sum));
            mant_reg <= bus.mant_prod;
            if (|bus.exc) begin
              result_reg <= exc_result;
              flags_reg  <= exc_flags;
            end
          end
        end
        NORM: begin
          if (mant_reg[PROD_W-1]) begin
            frac_reg   <= mant_reg[8:1];
            sticky_reg <= mant_reg[0];
            exp_reg    <= exp_reg + EXP_ONE;
          end else begin
            frac_reg   <= mant_reg[7:0];
            sticky_reg <= 1'b0;
          end
        end
        ROUND: begin
          result_reg <= pack_result;
          flags_reg  <= pack_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmult_pack_module.sv
// Directed bench for the multiplier pack stage: hand-computed vectors for the
// normal, rounding, range and exception paths, plus backpressure and reset.
module tb_fpmult_pack_module;
  import fpmult_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fpmult_pack_module_if bus ();

  fpmult_pack_module #(.BIAS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    logic [4:0] x;
    int         lat;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present a bundle, let it be accepted, then keep in_valid high with
  // garbage so any late sampling would corrupt the result.
  task automatic send(input logic s, input logic [4:0] e, input logic [9:0] m, input logic [4:0] x);
    @(negedge clk);
    chk("in_ready_before_send", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.sign      = s;
    bus.exp_sum   = e;
    bus.mant_prod = m;
    bus.exc       = x;
    @(posedge clk);
    #1;
    bus.sign      = ~s;
    bus.exp_sum   = 5'h0B;
    bus.mant_prod = 10'h3FF;
    bus.exc       = 5'h1F;
  endtask

  // Count cycles after the accept edge until out_valid (bounded).
  task automatic await(input string tag, input int lat);
    int n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (bus.out_valid === 1'b1) break;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_in_ready_low"}, {31'b0, bus.in_ready}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [7:0] res, input logic [3:0] flg);
    chk({tag, "_result"}, {24'b0, bus.result}, {24'b0, res});
    chk({tag, "_flags"}, {28'b0, bus.flags}, {28'b0, flg});
  endtask

  // Handshake with in_valid still high: the HOLD->IDLE edge must not accept.
  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, "_after_take_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_after_take_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{1'b0, 5'd3,  10'd256, 5'b00000, 3, 8'h30, 4'h0},  // 1.0*1.0
      '{1'b0, 5'd3,  10'd576, 5'b00000, 3, 8'h42, 4'h0},  // 1.5*1.5, shift
      '{1'b0, 5'd3,  10'd408, 5'b00000, 3, 8'h3A, 4'h1},  // tie, odd lsb rounds up
      '{1'b0, 5'd9,  10'd256, 5'b00000, 3, 8'h70, 4'h5},  // overflow
      '{1'b1, 5'd3,  10'd0,   5'b10010, 1, 8'hFC, 4'h8},  // inf*zero
      '{1'b0, 5'd3,  10'd264, 5'b00000, 3, 8'h30, 4'h1},  // tie, even lsb stays
      '{1'b0, 5'd3,  10'd504, 5'b00000, 3, 8'h40, 4'h1},  // rounding carry-out
      '{1'b0, 5'd6,  10'd504, 5'b00000, 3, 8'h70, 4'h5},  // carry pushes to overflow
      '{1'b0, 5'd3,  10'd961, 5'b00000, 3, 8'h4E, 4'h1},  // shifted-out bit sets sticky
      '{1'b1, 5'd0,  10'd256, 5'b00000, 3, 8'h80, 4'h3},  // exp 0 flushes
      '{1'b1, 5'h1D, 10'd500, 5'b00000, 3, 8'h80, 4'h3},  // exp -3 flushes
      '{1'b0, 5'd6,  10'd256, 5'b00000, 3, 8'h60, 4'h0},  // largest normal exponent
      '{1'b0, 5'd1,  10'd256, 5'b00000, 3, 8'h10, 4'h0},  // smallest normal exponent
      '{1'b0, 5'd0,  10'd0,   5'b11000, 1, 8'h7C, 4'h8},  // NaN beats zero
      '{1'b1, 5'd3,  10'd0,   5'b00001, 1, 8'hF0, 4'h0},  // infinity
      '{1'b1, 5'd3,  10'd0,   5'b10000, 1, 8'h80, 4'h0}   // zero
    };

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sign      = 1'b0;
    bus.exp_sum   = '0;
    bus.mant_prod = '0;
    bus.exc       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_out("reset", 8'h00, 4'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      string tag = $sformatf("vec%0d", i);
      send(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].x);
      await(tag, vecs[i].lat);
      check_out(tag, vecs[i].res, vecs[i].flg);
      take(tag);
      $display("vec%0d s=%0b e=%0h m=%0d x=%05b -> result=%02h flags=%04b", i,
               vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].x, vecs[i].res, vecs[i].flg);
    end

    // Backpressure: result stays put while out_ready is low, then reset in HOLD.
    send(1'b0, 5'd3, 10'd256, 5'b00000);
    await("bp", 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_result", c), {24'b0, bus.result}, 32'h30);
      chk($sformatf("bp_hold%0d_in_ready", c), {31'b0, bus.in_ready}, 32'd0);
      chk($sformatf("bp_hold%0d_out_valid", c), {31'b0, bus.out_valid}, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("bp_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("bp_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check_out("bp_rst", 8'h00, 4'h0);
    $display("backpressure: held 5 cycles, reset in HOLD");

    // Reset during NORM discards the bundle.
    send(1'b0, 5'd3, 10'd576, 5'b00000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b0) seen++;
      end
      chk("midrst_no_out_valid", seen, 0);
    end
    chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    $display("reset during NORM: bundle discarded");

    // Reset dominates in_valid in IDLE: nothing is accepted.
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.exc      = 5'b01000;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.exc      = '0;
    chk("rst_vs_in_valid_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_vs_in_valid_out_valid", {31'b0, bus.out_valid}, 32'd0);
    $display("reset with in_valid: no capture");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
